// File: rtl/load_store_unit_if.sv
// Data-memory port bundle between the load/store unit (master) and the
// data memory (slave): a valid/ready request channel carrying word address,
// byte strobes and store data, plus a valid-only read response channel.
interface load_store_unit_if #(
    parameter int WADDR_W = 30
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [WADDR_W-1:0] mem_addr;
    logic [3:0]         mem_we;
    logic [31:0]        mem_wdata;
    logic               mem_rsp_valid;
    logic [31:0]        mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the memory stage. Checks width code and alignment,
// issues one valid/ready request per instruction to data memory, waits for
// the read word on loads, then byte-aligns and extends it into o_load_data.
// o_stall holds the upstream pipeline until the access has completed; a
// one-cycle stall-free DONE state lets the instruction retire exactly once.
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int WADDR_W = 30
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_stall,
    output logic [31:0]       o_load_data,
    output logic              o_access_fault,
    load_store_unit_if.master mem
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RSP = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]         r_state;
    logic [1:0]         r_off;
    logic [2:0]         r_funct3;
    logic               r_write;
    logic               r_mem_req_valid;
    logic [WADDR_W-1:0] r_mem_addr;
    logic [3:0]         r_mem_we;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_load_data;
    logic               r_access_fault;

    logic               w_legal;
    logic               w_aligned;
    logic               w_issue;
    logic [3:0]         w_we;
    logic [31:0]        w_wdata;

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] data,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (off)
            2'd0:    v_byte = data[7:0];
            2'd1:    v_byte = data[15:8];
            2'd2:    v_byte = data[23:16];
            default: v_byte = data[31:24];
        endcase
        v_half = off[1] ? data[31:16] : data[15:0];
        case (f3)
            F3_B:    extract = {{24{v_byte[7]}}, v_byte};
            F3_BU:   extract = {24'd0, v_byte};
            F3_H:    extract = {{16{v_half[15]}}, v_half};
            F3_HU:   extract = {16'd0, v_half};
            default: extract = data;
        endcase
    endfunction

    // Decode legality of the width code and natural alignment of the address.
    always_comb begin
        case (i_req_funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = !i_req_write;
            default:          w_legal = 1'b0;
        endcase
        case (i_req_funct3)
            F3_H, F3_HU: w_aligned = !i_req_addr[0];
            F3_W:        w_aligned = (i_req_addr[1:0] == 2'b00);
            default:     w_aligned = 1'b1;
        endcase
        w_issue = i_req_valid && w_legal && w_aligned;
    end

    // Byte strobes and lane-replicated store data; loads drive no strobes.
    always_comb begin
        w_we    = 4'b0000;
        w_wdata = i_req_wdata;
        if (i_req_write) begin
            case (i_req_funct3)
                F3_B: begin
                    w_we    = 4'b0001 << i_req_addr[1:0];
                    w_wdata = {4{i_req_wdata[7:0]}};
                end
                F3_H: begin
                    w_we    = i_req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_req_wdata[15:0]}};
                end
                default: begin
                    w_we    = 4'b1111;
                    w_wdata = i_req_wdata;
                end
            endcase
        end
    end

    // Stall while an access is being launched or is in flight; DONE releases it.
    always_comb begin
        case (r_state)
            S_IDLE:     o_stall = w_issue;
            S_REQ:      o_stall = 1'b1;
            S_WAIT_RSP: o_stall = 1'b1;
            default:    o_stall = 1'b0;
        endcase
    end

    // Access sequencer: launch, hold request until accepted, collect response.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state         <= S_IDLE;
            r_off           <= 2'b00;
            r_funct3        <= 3'b000;
            r_write         <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_we        <= 4'b0000;
            r_mem_wdata     <= 32'd0;
            r_load_data     <= 32'd0;
            r_access_fault  <= 1'b0;
        end else begin
            r_access_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_off           <= i_req_addr[1:0];
                        r_funct3        <= i_req_funct3;
                        r_write         <= i_req_write;
                        r_mem_addr      <= i_req_addr[ADDR_W-1:2];
                        r_mem_we        <= w_we;
                        r_mem_wdata     <= w_wdata;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end else if (i_req_valid) begin
                        // Faulting instruction retires without touching memory.
                        r_access_fault <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= r_write ? S_DONE : S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    if (mem.mem_rsp_valid) begin
                        r_load_data <= extract(mem.mem_rsp_data, r_funct3, r_off);
                        r_state     <= S_DONE;
                    end
                end
                default: begin
                    // DONE: the stalled instruction advances now; never reissue it.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req_valid = r_mem_req_valid;
    assign mem.mem_addr      = r_mem_addr;
    assign mem.mem_we        = r_mem_we;
    assign mem.mem_wdata     = r_mem_wdata;
    assign o_load_data       = r_load_data;
    assign o_access_fault    = r_access_fault;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Drives the data-memory port on behalf of the memory stage and supplies the aligned, extended load word that the memory stage forwards as `dout`.
- Accepts one load/store per instruction from the EX/MEM boundary and issues a valid/ready request to data memory.
- Waits for the read response, then byte-aligns and sign/zero-extends it.
- Holds the pipeline with `stall` until the access completes.

Parameters:
- ADDR_W, 32, byte-address width of `req_addr`.
- WADDR_W, 30, word-address width of `mem_addr` (must equal ADDR_W-2).

Ports:
- clk  in  1  pipeline clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  memory instruction present in memory stage
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data (rs2, unshifted)
- stall  out  1  hold all upstream stages this cycle
- load_data  out  32  aligned/extended load result, to memory stage `dout`
- access_fault  out  1  one-cycle pulse: misaligned address or illegal funct3
- mem_req_valid  out  1  request to data memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  WADDR_W  word address
- mem_we  out  4  byte write strobes; 0000 = read
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read word

Behaviour:
- Reset state: FSM=IDLE; stall, access_fault, mem_req_valid = 0; mem_we = 0; mem_addr, mem_wdata, load_data = 0.
- All mem_* outputs, load_data and access_fault are registered.
- stall is combinational from state and the req_* inputs.
- Legal funct3 values: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores accept only 000/001/010.
  - Any other value is illegal.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - req_valid & legal & aligned: stall=1; capture addr[1:0], funct3 and write; load mem_addr=addr[ADDR_W-1:2], mem_we, mem_wdata; mem_req_valid<=1; next state REQ.
  - req_valid & (illegal | misaligned): no memory transaction; stall=0; access_fault=1 the next cycle for one cycle; load_data unchanged; stay in IDLE.
- REQ:
  - stall=1; mem_req_valid, mem_addr, mem_we, mem_wdata held stable until mem_req_ready.
  - On handshake: mem_req_valid<=0; a store goes to DONE, a load goes to WAIT_RSP.
- WAIT_RSP:
  - stall=1.
  - On mem_rsp_valid: load_data <= extract(mem_rsp_data); next state DONE.
- DONE:
  - stall=0 for exactly one cycle, so the pipeline advances; next state IDLE.
  - req_valid is ignored in DONE, so the same instruction is never reissued.
- Store lanes:
  - B: mem_we=0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - H: mem_we=0011<<(2*addr[1]); mem_wdata={2{wdata[15:0]}}.
  - W: mem_we=1111; mem_wdata=wdata.
  - Loads: mem_we=0000.
- Load extract: select the byte at data[8*addr[1:0]+:8] or the half at data[16*addr[1]+:16].
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: pass through.
- load_data holds its value until the next load completes (stores and faults do not change it).
- mem_rsp_valid outside WAIT_RSP is ignored.
- mem_req_ready outside REQ is ignored.
- Minimum latency: load with ready and response immediate = 3 stall cycles (IDLE, REQ, WAIT_RSP) then DONE. Store = 2 stall cycles.
- Reset mid-operation (any state): return to IDLE and drop mem_req_valid the next cycle. A late response after reset is ignored.

Test Plan:
- LW addr 0x100, ready high in REQ, rsp 0xDEADBEEF two cycles later -> mem_addr=0x40, mem_we=0000; stall high 4 cycles then low 1 cycle; load_data=0xDEADBEEF.
- SB addr 0x203, wdata 0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80; 2 stall cycles then DONE; load_data unchanged.
- LH addr 0x6, rsp 0x8001_1234 -> load_data=0xFFFF8001. LHU same -> 0x00008001. LBU addr 0x5, rsp 0x0000_7F00 -> 0x0000007F.
- LW addr 0x102 -> no mem_req_valid; access_fault pulses once; stall never asserted. funct3=011 behaves the same.
- SW with mem_req_ready low 3 cycles -> mem_req_valid, mem_addr, mem_we, mem_wdata stable for all 4 REQ cycles; single handshake; stall released 1 cycle after acceptance.
- Load in WAIT_RSP, rstn low 1 cycle, then rsp arrives -> state IDLE, mem_req_valid=0, load_data=0, response ignored; next LW completes normally.
